argmax_classifier: RTL
======================

ARGMAX_CLASSIFIER -- requirements
Module: argmax_classifier

Interface
REQ-001 Parameter IN_COUNT, default 10: number of class scores consumed per classification; minimum 2.
REQ-002 Parameter DATA_SIZE, default 16: width of each signed two's-complement score.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin a new classification.
REQ-006 dataIn  input  DATA_SIZE  signed score from the upstream dense layer output stream.
REQ-007 dataValid  input  1  dataIn holds a valid score this cycle.
REQ-008 dataReady  output  1  block accepts a score this cycle; a transfer occurs when dataValid and dataReady are both high.
REQ-009 busy  output  1  high while a classification is in progress.
REQ-010 done  output  1  one-cycle pulse marking a new valid result.
REQ-011 classIdx  output  $clog2(IN_COUNT)  index of the maximum score in the last completed classification.
REQ-012 maxValue  output  DATA_SIZE  maximum score of the last completed classification.

Function
REQ-013 The state machine SHALL have states IDLE, RECV and FINISH; IDLE is entered from reset.
REQ-014 IDLE -> RECV on start; score counter cleared; running max/index invalidated.
REQ-015 In IDLE, dataReady SHALL be low and dataValid SHALL be ignored, including a dataValid coincident with start.
REQ-016 In RECV, dataReady and busy SHALL be high; each transfer increments the score counter 0..IN_COUNT-1.
REQ-017 Transfer at index 0 SHALL load the running max and running index unconditionally.
REQ-018 A transfer at index k>0 SHALL replace the running max/index only if dataIn is strictly greater (signed compare); ties keep the lower index.
REQ-019 Cycles in RECV without dataValid SHALL leave all state unchanged (no timeout).
REQ-020 The transfer at index IN_COUNT-1 SHALL move RECV -> FINISH and wrap the counter to 0.
REQ-021 In FINISH (exactly one cycle) classIdx/maxValue SHALL be updated from the running registers, done SHALL pulse high, busy SHALL stay high, dataReady SHALL be low; next state IDLE.
REQ-022 Latency: done is high in the cycle immediately following the last transfer; a full classification with back-to-back valid data takes IN_COUNT+2 cycles from start to done.
REQ-023 start while in RECV or FINISH SHALL be ignored.
REQ-024 classIdx and maxValue SHALL hold their values from the previous FINISH until the next FINISH; they never show partial results.
REQ-025 busy SHALL be low only in IDLE.

Reset
REQ-026 Asserting rst (low) at any time, including mid-RECV, SHALL immediately force IDLE, counter 0, running registers 0, classIdx 0, maxValue 0, done 0, dataReady 0, busy 0.
REQ-027 After rst deasserts, no transfer SHALL occur until a new start.

Structure
REQ-028 State encodings (IDLE, RECV, FINISH) and the default IN_COUNT/DATA_SIZE constants SHALL live in the shared project package/header used by the dense blocks.
REQ-029 The score counter SHALL be an instance of the existing LoopCounter sub-module (parameter IN_COUNT, co used as last-transfer flag); everything else is local RTL.

Verification
REQ-030 IN_COUNT=10, start then scores 3,-1,7,2,0,5,7,1,-4,6 back-to-back -> done 12 cycles after start, classIdx=2, maxValue=7 (tie at index 6 rejected).
REQ-031 All ten scores negative (-50,-9,-30,...,-100, max -9 at index 1) -> classIdx=1, maxValue=-9 (signed compare, not unsigned).
REQ-032 Scores with dataValid toggling every other cycle plus dataValid pulses before start -> same result as contiguous stream; pre-start data ignored; done one cycle after tenth transfer.
REQ-033 rst low after 4 transfers, then new start with max 0x7FFF at index 9 -> all outputs 0 during reset, final classIdx=9, maxValue=32767.
REQ-034 Extra start pulses during RECV and FINISH -> no restart, single done pulse, correct result; classIdx/maxValue unchanged until that done.

Source files
------------

// File: rtl/argmax_classifier_pkg.sv
// rtl/argmax_classifier_pkg.sv - shared constants and state encoding for the argmax classifier
// Purpose: default IN_COUNT/DATA_SIZE values and the classifier FSM state type,
//          shared with the dense-layer blocks.
package argmax_classifier_pkg;

  localparam int DEF_IN_COUNT  = 10;
  localparam int DEF_DATA_SIZE = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECV   = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

endpackage

// File: rtl/argmax_classifier_loop_counter.sv
// rtl/argmax_classifier_loop_counter.sv - wrapping 0..COUNT-1 loop counter with carry-out
// Purpose: counts enabled cycles from 0 to COUNT-1, then wraps to 0.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr_i       synchronous clear to 0 (wins over en_i)
//   en_i        advance the count this cycle
//   cnt_o       current count
//   co_o        high when en_i is set while the count sits at COUNT-1
module argmax_classifier_loop_counter #(
  parameter int COUNT = 10,
  parameter int CW    = (COUNT > 1) ? $clog2(COUNT) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] cnt_o,
  output logic          co_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  assign cnt_o = cnt_q;
  assign co_o  = en_i && (cnt_q == CW'(COUNT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = co_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/argmax_classifier.sv
// rtl/argmax_classifier.sv - streaming argmax over IN_COUNT signed class scores
// Purpose: after a start pulse, accepts IN_COUNT scores over a valid/ready
//          handshake and reports the index and value of the largest one.
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   start                 one-cycle request to begin (honoured only when idle)
//   dataIn, dataValid     signed score stream from the dense layer
//   dataReady             score accepted this cycle when dataValid is also high
//   busy                  high from the cycle after start until the done cycle
//   done                  one-cycle pulse, result valid on classIdx/maxValue
//   classIdx, maxValue    result of the last completed classification
module argmax_classifier
  import argmax_classifier_pkg::*;
#(
  parameter int IN_COUNT  = DEF_IN_COUNT,
  parameter int DATA_SIZE = DEF_DATA_SIZE
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [DATA_SIZE-1:0]        dataIn,
  input  logic                        dataValid,
  output logic                        dataReady,
  output logic                        busy,
  output logic                        done,
  output logic [$clog2(IN_COUNT)-1:0] classIdx,
  output logic [DATA_SIZE-1:0]        maxValue
);

  localparam int IW = $clog2(IN_COUNT);

  state_e               state_q, state_d;
  logic [IW-1:0]        cnt;
  logic                 last;
  logic                 xfer;
  logic                 begin_run;
  logic                 take;
  logic [DATA_SIZE-1:0] run_max_q, run_max_d;
  logic [IW-1:0]        run_idx_q, run_idx_d;
  logic [DATA_SIZE-1:0] res_max_q, res_max_d;
  logic [IW-1:0]        res_idx_q, res_idx_d;

  assign dataReady = (state_q == ST_RECV);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_FINISH);
  assign classIdx  = res_idx_q;
  assign maxValue  = res_max_q;

  assign xfer      = dataValid && dataReady;
  assign begin_run = (state_q == ST_IDLE) && start;

  argmax_classifier_loop_counter #(
    .COUNT (IN_COUNT),
    .CW    (IW)
  ) u_score_cnt (
    .clk   (clk),
    .rst_n (rst),
    .clr_i (begin_run),
    .en_i  (xfer),
    .cnt_o (cnt),
    .co_o  (last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_RECV;
      ST_RECV:   if (last)  state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Index 0 always loads; later scores must be strictly greater so ties keep
  // the lower index.
  assign take = (cnt == '0) || ($signed(dataIn) > $signed(run_max_q));

  // The result registers take the merged value on the last transfer, so the
  // final score is already included when done is shown in FINISH.
  always_comb begin
    run_max_d = run_max_q;
    run_idx_d = run_idx_q;
    res_max_d = res_max_q;
    res_idx_d = res_idx_q;
    if (begin_run) begin
      run_max_d = '0;
      run_idx_d = '0;
    end else if (xfer) begin
      if (take) begin
        run_max_d = dataIn;
        run_idx_d = cnt;
      end
      if (last) begin
        res_max_d = run_max_d;
        res_idx_d = run_idx_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      run_max_q <= '0;
      run_idx_q <= '0;
      res_max_q <= '0;
      res_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      run_max_q <= run_max_d;
      run_idx_q <= run_idx_d;
      res_max_q <= res_max_d;
      res_idx_q <= res_idx_d;
    end
  end

endmodule
